sap_cpu_core: RTL

//  Parametrised successor to the 8-bit bus CPU: SAP-style accumulator core with internal program RAM.

---
 rtl/sap_cpu_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU with internal program RAM, five micro-steps per instruction,
// carry/zero flags, conditional jumps and a registered output port.
module sap_cpu_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [1:0]        flags_dbg
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    step_t step_q, step_d;

    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, a, b;
    logic              c, z;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic              is_sub;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   alu_sum;

    assign run       = clk_en & ~prog_mode & ~halted;
    assign opcode    = ir[DATA_W-1 -: 4];
    assign operand   = ir[ADDR_W-1:0];
    assign ram_rd    = mem[mar];
    assign pc_dbg    = pc;
    assign flags_dbg = {c, z};

    // SUB is A + ~B + 1 so that carry-out doubles as "no borrow"
    always_comb begin
        is_sub  = (opcode == OP_SUB);
        b_op    = is_sub ? ~b : b;
        alu_sum = {1'b0, a} + {1'b0, b_op} + (DATA_W + 1)'(is_sub);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) step_q <= T0;
        else     step_q <= step_d;
    end

    // Micro-step sequencing; HLT parks the sequencer in T2
    always_comb begin
        step_d = step_q;
        if (prog_mode) begin
            step_d = T0;
        end else if (run) begin
            case (step_q)
                T0:      step_d = T1;
                T1:      step_d = T2;
                T2:      step_d = (opcode == OP_HLT) ? T2 : T3;
                T3:      step_d = T4;
                default: step_d = T0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= 1'b0;
            z         <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (prog_mode) begin
                pc     <= '0;
                halted <= 1'b0;
            end else if (run) begin
                case (step_q)
                    T0: mar <= pc;
                    T1: begin
                        ir <= ram_rd;
                        pc <= pc + ADDR_W'(1);
                    end
                    T2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                            OP_LDI: a  <= DATA_W'(operand);
                            OP_JMP: pc <= operand;
                            OP_JC:  if (c) pc <= operand;
                            OP_JZ:  if (z) pc <= operand;
                            OP_OUT: begin
                                out_data  <= a;
                                out_valid <= 1'b1;
                            end
                            OP_HLT: halted <= 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (opcode)
                            OP_LDA:         a <= ram_rd;
                            OP_ADD, OP_SUB: b <= ram_rd;
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            {c, a} <= alu_sum;
                            z      <= (alu_sum[DATA_W-1:0] == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM is deliberately not reset; rst blocks a pending STA write
    always_ff @(posedge clk) begin
        if (prog_mode) begin
            if (prog_we) mem[prog_addr] <= prog_data;
        end else if (!rst && run && step_q == T3 && opcode == OP_STA) begin
            mem[mar] <= a;
        end
    end

endmodule
